// File: rtl/seq_lane_mem_if.sv
// Bus bundle between the game controller (master) and the sequence lane memory (slave).
// Widths follow LANE_W / DEPTH and must match the attached seq_lane_mem instance.
interface seq_lane_mem_if #(
    parameter int LANE_W = 8,
    parameter int DEPTH  = 4
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic                    MEM_CLR;
    logic                    MEM_LOAD;
    logic [PTR_W-1:0]        MEM_LOAD_VAL;
    logic                    MEM_APPEND;
    logic [LANE_W-1:0]       MEM_IN;
    logic                    RD_START;
    logic                    RD_NEXT;
    logic [LANE_W-1:0]       RD_DATA;
    logic                    RD_VALID;
    logic                    RD_LAST;
    logic [LEN_W-1:0]        MEM_LEN;
    logic                    MEM_FULL;
    logic [DEPTH*LANE_W-1:0] MEM_OUT;

    modport master (
        output MEM_CLR, MEM_LOAD, MEM_LOAD_VAL, MEM_APPEND, MEM_IN, RD_START, RD_NEXT,
        input  RD_DATA, RD_VALID, RD_LAST, MEM_LEN, MEM_FULL, MEM_OUT
    );

    modport slave (
        input  MEM_CLR, MEM_LOAD, MEM_LOAD_VAL, MEM_APPEND, MEM_IN, RD_START, RD_NEXT,
        output RD_DATA, RD_VALID, RD_LAST, MEM_LEN, MEM_FULL, MEM_OUT
    );
endinterface

// File: rtl/seq_lane_mem.sv
// DEPTH x LANE_W sequence store with indexed/append writes, length tracking and playback.
// Define SEQ_LANE_MEM_WRAP_EN for circular history (append while full overwrites the oldest lane).
module seq_lane_mem #(
    parameter int LANE_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst_MEM,
    seq_lane_mem_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic [LANE_W-1:0] mem_q [DEPTH];
    logic [LANE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              full_q, full_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last;
    logic [PTR_W-1:0]  base;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // rd_cnt only ever reaches len_q-1 while valid, so the subtraction never underflows in use.
    assign rd_last = rd_valid_q && (rd_cnt_q == (len_q - LEN_W'(1)));

`ifdef SEQ_LANE_MEM_WRAP_EN
    assign base = full_q ? wr_ptr_q : '0;
`else
    assign base = '0;
`endif

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_cnt_d   = rd_cnt_q;
        len_d      = len_q;
        rd_valid_d = rd_valid_q;

        if (bus.MEM_CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            rd_cnt_d   = '0;
            len_d      = '0;
            rd_valid_d = 1'b0;
        end else begin
            if (bus.MEM_LOAD) begin
                if (int'(bus.MEM_LOAD_VAL) < DEPTH) begin
                    mem_d[bus.MEM_LOAD_VAL] = bus.MEM_IN;
                end
            end else if (bus.MEM_APPEND) begin
                if (!full_q) begin
                    mem_d[wr_ptr_q] = bus.MEM_IN;
                    wr_ptr_d        = ptr_inc(wr_ptr_q);
                    len_d           = len_q + LEN_W'(1);
                end
`ifdef SEQ_LANE_MEM_WRAP_EN
                else begin
                    mem_d[wr_ptr_q] = bus.MEM_IN;
                    wr_ptr_d        = ptr_inc(wr_ptr_q);
                end
`endif
            end

            if (bus.RD_START) begin
                rd_ptr_d   = base;
                rd_cnt_d   = '0;
                rd_valid_d = (len_q != '0);
            end else if (bus.RD_NEXT && rd_valid_q) begin
                if (rd_last) begin
                    rd_valid_d = 1'b0;
                end else begin
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                    rd_cnt_d = rd_cnt_q + LEN_W'(1);
                end
            end
        end

        full_d = (len_d == LEN_W'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst_MEM) begin
        if (rst_MEM) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            len_q      <= '0;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_cnt_q   <= rd_cnt_d;
            len_q      <= len_d;
            full_q     <= full_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign bus.MEM_OUT[g*LANE_W +: LANE_W] = mem_q[g];
    end

    assign bus.RD_DATA  = rd_valid_q ? mem_q[rd_ptr_q] : '0;
    assign bus.RD_VALID = rd_valid_q;
    assign bus.RD_LAST  = rd_last;
    assign bus.MEM_LEN  = len_q;
    assign bus.MEM_FULL = full_q;
endmodule
